// File: rtl/gbc_apu_sequencer_if.sv
// Wishbone initiator bundle carrying one mixed audio sample per write.
// The sequencer drives the master side and the audio bus sink is the slave.
interface gbc_apu_sequencer_if #(
   parameter int sample_width = 24
);
   logic                    cyc;
   logic                    stb;
   logic                    we;
   logic [sample_width-1:0] dat;
   logic                    ack;
   logic                    stall;

   modport master (output cyc, stb, we, dat, input ack, stall);
   modport slave  (input cyc, stb, we, dat, output ack, stall);
endinterface

// File: rtl/gbc_apu_sequencer.sv
// GBC APU timing: 512 Hz frame sequencer off DIV, fractional 48 kHz sample strobe,
// and a Wishbone initiator that pushes each latched sample with a one-deep shadow.
module gbc_apu_sequencer #(
   parameter int ce_hz        = 4194304,
   parameter int sample_hz    = 48000,
   parameter int sample_width = 24
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    ce,
   input  logic                    gb2x,
   input  logic                    apu_enable,
   input  logic                    div_write,
   input  logic [sample_width-1:0] mix_sample,
   output logic [2:0]              step,
   output logic                    length_tick,
   output logic                    sweep_tick,
   output logic                    envelope_tick,
   output logic                    sample_strobe,
   gbc_apu_sequencer_if.master     wb,
   output logic [7:0]              overrun
);

   localparam logic [1:0]  s_idle   = 2'd0;
   localparam logic [1:0]  s_req    = 2'd1;
   localparam logic [1:0]  s_wait   = 2'd2;
   localparam logic [24:0] limit_1x = 25'(ce_hz);
   localparam logic [24:0] limit_2x = 25'(2 * ce_hz);
   localparam logic [24:0] acc_inc  = 25'(sample_hz);

   logic [13:0]             div;
   logic [13:0]             div_next;
   logic                    tap_cur;
   logic                    tap_nxt;
   logic                    frame_event;
   logic [23:0]             acc;
   logic [24:0]             acc_sum;
   logic [24:0]             limit;
   logic [1:0]              state;
   logic                    pending;
   logic                    shadow_valid;
   logic [sample_width-1:0] slot;
   logic [sample_width-1:0] shadow;
   logic                    completing;

   always_comb begin
      // NOTE: default first, then overrides, so no latch is inferred on any path.
      div_next = div;
      if (div_write)
         div_next = '0;
      else if (ce)
         div_next = div + 14'd1;
   end

   // Both taps are read with the current speed, so switching GB2x alone is never an edge.
   assign tap_cur     = gb2x ? div[13]      : div[12];
   assign tap_nxt     = gb2x ? div_next[13] : div_next[12];
   assign frame_event = tap_cur & ~tap_nxt;

   assign acc_sum = {1'b0, acc} + acc_inc;
   assign limit   = gb2x ? limit_2x : limit_1x;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div           <= '0;
         acc           <= '0;
         sample_strobe <= 1'b0;
      end else begin
         div           <= div_next;
         sample_strobe <= 1'b0;
         if (ce) begin
            if (acc_sum >= limit) begin
               acc           <= 24'(acc_sum - limit);
               sample_strobe <= 1'b1;
            end else begin
               acc <= acc_sum[23:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         step          <= 3'd0;
         length_tick   <= 1'b0;
         sweep_tick    <= 1'b0;
         envelope_tick <= 1'b0;
      end else begin
         length_tick   <= 1'b0;
         sweep_tick    <= 1'b0;
         envelope_tick <= 1'b0;
         if (!apu_enable) begin
            step <= 3'd0;
         end else if (frame_event) begin
            case (step)
               3'd0, 3'd4: length_tick <= 1'b1;
               3'd2, 3'd6: begin
                  length_tick <= 1'b1;
                  sweep_tick  <= 1'b1;
               end
               3'd7:       envelope_tick <= 1'b1;
               default:    ;
            endcase
            step <= step + 3'd1;
         end
      end
   end

   assign completing = ((state == s_wait) && wb.ack) ||
                       ((state == s_req) && !wb.stall && wb.ack);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= s_idle;
         wb.cyc       <= 1'b0;
         wb.stb       <= 1'b0;
         wb.we        <= 1'b0;
         wb.dat       <= '0;
         pending      <= 1'b0;
         shadow_valid <= 1'b0;
         slot         <= '0;
         shadow       <= '0;
         overrun      <= 8'd0;
      end else begin
         case (state)
            s_idle: begin
               if (pending) begin
                  wb.cyc <= 1'b1;
                  wb.stb <= 1'b1;
                  wb.we  <= 1'b1;
                  wb.dat <= slot;
                  state  <= s_req;
               end
            end
            s_req: begin
               if (!wb.stall) begin
                  wb.stb <= 1'b0;
                  if (wb.ack) begin
                     wb.cyc <= 1'b0;
                     wb.we  <= 1'b0;
                     state  <= s_idle;
                  end else begin
                     state <= s_wait;
                  end
               end
            end
            s_wait: begin
               if (wb.ack) begin
                  wb.cyc <= 1'b0;
                  wb.we  <= 1'b0;
                  state  <= s_idle;
               end
            end
            default: state <= s_idle;
         endcase

         // slot holds the sample on the bus; shadow holds the newest one waiting behind it
         if (completing) begin
            if (sample_strobe) begin
               slot         <= mix_sample;
               pending      <= 1'b1;
               shadow_valid <= 1'b0;
            end else if (shadow_valid) begin
               slot         <= shadow;
               pending      <= 1'b1;
               shadow_valid <= 1'b0;
            end else begin
               pending <= 1'b0;
            end
         end else if (sample_strobe) begin
            if (!pending) begin
               slot    <= mix_sample;
               pending <= 1'b1;
            end else begin
               shadow       <= mix_sample;
               shadow_valid <= 1'b1;
               if ((state != s_idle) && (overrun != 8'hFF))
                  overrun <= overrun + 8'd1;
            end
         end
      end
   end

endmodule

// File: doc/gbc_apu_sequencer.md
Name: gbc_apu_sequencer

Overview:
Timing scheduler for the GBC audio unit inside the IO system. It derives the 512 Hz frame-sequencer steps (length, sweep, envelope clocks) from the Gameboy Ce pace. It also generates the 48 kHz output sample strobe with a fractional accumulator. It drives the Wishbone initiator that pushes each mixed sample to the audio bus, holding a one-deep buffer between strobe and bus.

Parameters:
CeHz, 4194304, Ce pulses per second in single-speed mode (doubled internally when GB2x=1)
SampleHz, 48000, output sample rate
SampleWidth, 24, sample width in bits

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
Ce  in  1  Gameboy clock enable; all sequencing advances only on Ce=1
GB2x  in  1  double-speed mode
ApuEnable  in  1  NR52 bit 7 (APU power)
DivWrite  in  1  one-cycle pulse: CPU write to DIV ($FF04)
MixSample  in  SampleWidth  current mixer output, sampled at strobe
Step  out  3  index of next frame step to execute
LengthTick  out  1  one-Clk pulse: clock length counters
SweepTick  out  1  one-Clk pulse: clock pulse-1 sweep
EnvelopeTick  out  1  one-Clk pulse: clock envelopes
SampleStrobe  out  1  one-Clk pulse: sample captured
WbCyc  out  1  Wishbone cycle
WbStb  out  1  Wishbone strobe
WbWe  out  1  write enable (constant 1 while WbCyc)
WbDat  out  SampleWidth  sample data, little-endian
WbAck  in  1  Wishbone acknowledge
WbStall  in  1  Wishbone pipelined stall
Overrun  out  8  saturating count of samples dropped

Behaviour:
- Reset (Reset_n=0, async): Div=0, Step=0, Acc=0, all tick/strobe outputs 0, WbCyc=WbStb=WbWe=0, WbDat=0, Overrun=0, pending=0.
- Div: 14-bit counter, +1 per Ce. Tap is Div[12] when GB2x=0, Div[13] when GB2x=1. Both taps give 512 Hz real time.
- Frame event: falling edge of the selected tap, detected against its value in the previous Clk cycle. An event registered at cycle N drives ticks in cycle N+1 (1-cycle latency). Ticks are single-cycle.
- DivWrite: Div cleared to 0 on the same cycle. If the tap was 1, this counts as a falling edge and causes an extra frame event. DivWrite has priority over the Ce increment.
- GB2x change: tap reselection is not itself an edge. Update the previous-tap register to the new tap on the switching cycle.
- Step actions on event:
  - 0: Length
  - 1: none
  - 2: Length + Sweep
  - 3: none
  - 4: Length
  - 5: none
  - 6: Length + Sweep
  - 7: Envelope
  - Step then increments, wrapping 7 to 0.
- ApuEnable=0: Step forced to 0, no ticks. Div keeps counting. Enable rising edge leaves Step=0, so the first event executes step 0.
- Sample accumulator Acc (24-bit): on each Ce, Acc += SampleHz.
  - If the sum is >= Limit (CeHz, or 2*CeHz when GB2x=1), subtract Limit in the same cycle and assert SampleStrobe next cycle.
  - Long-run mean: 48000 strobes per 4194304 Ce single-speed.
  - Strobes continue while ApuEnable=0; the mixer supplies zero.
- Sample buffer: on SampleStrobe, MixSample latched into the pending slot.
- Wishbone initiator states: IDLE, REQ, WAIT.
  - IDLE: pending=1 → drive WbCyc=WbStb=WbWe=1, WbDat=slot; go to REQ.
  - REQ: WbStall=0 → drop WbStb; go to WAIT. WbStall=1 → hold WbStb and WbDat stable.
  - WAIT: WbAck=1 → WbCyc=0, pending cleared; go to IDLE.
  - Ack in the same cycle as the accepted strobe: treat as REQ→IDLE directly.
- Overrun: a strobe arriving while pending=1 and the state is not IDLE increments Overrun, saturating at 255. The new sample is kept in a shadow slot, overwriting any older shadow. It is transmitted after the current transfer completes. Data already on WbDat is never changed mid-transfer.
- Strobe coincident with WbAck: no overrun. The shadow becomes pending next cycle.
- Reset mid-transfer drops WbCyc immediately, asynchronously.

Test Plan:
- Ce every cycle, GB2x=0, ApuEnable=1, 65536 Ce → exactly 8 events. Ticks as per table: Length 4, Sweep 2, Envelope 1. Step returns to 0.
- GB2x=1, 65536 Ce → 4 events; Step=4 after.
- Div=0x1000 (tap=1), DivWrite → event on next cycle, LengthTick=1 at Step 0. DivWrite at Div=0x0800 → no event.
- ApuEnable 1→0 at Step=5, then 1 → Step=0, and the next event pulses LengthTick.
- 4194304 Ce, WbAck immediate → exactly 48000 SampleStrobes and 48000 Wishbone writes with WbDat equal to MixSample at each strobe. Overrun=0.
- WbStall=1 held through three strobes (samples 0xA, 0xB, 0xC) → WbDat stays 0xA. Overrun=2. After release, 0xA then 0xC are transmitted.
